// File: rtl/mem_write_checker_if.sv
// Bus bundle between a memory-write source (bench or CPU wrapper) and mem_write_checker.
//   master : drives the observed write port, the table load port and start; reads results
//   slave  : the checker; samples the write/load/start signals and drives the result signals
// Signals:
//   memwrite/dataadr/writedata      observed memory write port
//   exp_we/exp_idx/exp_addr/exp_data expected-write table load port
//   start                           begin a check run (single-cycle pulse)
//   done/pass/fail_code             result flags and failure reason
//   match_count/cycle_count         progress counters
//   err_addr/err_data               write captured on mismatch
interface mem_write_checker_if #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned NUM_EXP     = 4,
   parameter int unsigned TIMEOUT_CYC = 1000
);
   localparam int unsigned IDX_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic              memwrite;
   logic [ADDR_W-1:0] dataadr;
   logic [DATA_W-1:0] writedata;
   logic              exp_we;
   logic [IDX_W-1:0]  exp_idx;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_data;
   logic              start;
   logic              done;
   logic              pass;
   logic [1:0]        fail_code;
   logic [IDX_W:0]    match_count;
   logic [CNT_W-1:0]  cycle_count;
   logic [ADDR_W-1:0] err_addr;
   logic [DATA_W-1:0] err_data;

   modport master (
      output memwrite, dataadr, writedata, exp_we, exp_idx, exp_addr, exp_data, start,
      input  done, pass, fail_code, match_count, cycle_count, err_addr, err_data
   );

   modport slave (
      input  memwrite, dataadr, writedata, exp_we, exp_idx, exp_addr, exp_data, start,
      output done, pass, fail_code, match_count, cycle_count, err_addr, err_data
   );
endinterface

// File: rtl/mem_write_checker.sv
// Self-checking monitor for a memory write port. Compares observed writes against a loadable
// table of expected (address, data) pairs, in order (MODE 1), or accepts the first write (MODE 0).
// Ports:
//   i_clk      rising-edge clock
//   i_reset_n  synchronous active-low reset
//   bus        mem_write_checker_if.slave (write port, table load, start, results)
// fail_code: 0 none, 1 mismatch, 2 timeout, 3 table incomplete at start.
module mem_write_checker #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned NUM_EXP     = 4,
   parameter int unsigned TIMEOUT_CYC = 1000,
   parameter int unsigned MODE        = 1
) (
   input logic          i_clk,
   input logic          i_reset_n,
   mem_write_checker_if.slave bus
);
   localparam int unsigned IDX_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
   localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(NUM_EXP - 1);

   typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

   state_e             r_state;
   logic [ADDR_W-1:0]  r_exp_addr [NUM_EXP];
   logic [DATA_W-1:0]  r_exp_data [NUM_EXP];
   logic [NUM_EXP-1:0] r_valid;
   logic [IDX_W-1:0]   r_ptr;
   logic               r_done;
   logic               r_pass;
   logic [1:0]         r_fail_code;
   logic [IDX_W:0]     r_match_count;
   logic [CNT_W-1:0]   r_cycle_count;
   logic [ADDR_W-1:0]  r_err_addr;
   logic [DATA_W-1:0]  r_err_data;

   logic               w_load;
   logic               w_hit;
   logic               w_last_cycle;
   logic [CNT_W-1:0]   w_cycle_inc;

   // Table is writable whenever no run is in progress.
   assign w_load       = (r_state != StRun) && bus.exp_we && (32'(bus.exp_idx) < NUM_EXP);
   assign w_hit        = (bus.dataadr == r_exp_addr[r_ptr]) && (bus.writedata == r_exp_data[r_ptr]);
   assign w_last_cycle = (r_cycle_count == CNT_LAST);
   assign w_cycle_inc  = (r_cycle_count == CNT_MAX) ? r_cycle_count : r_cycle_count + 1'b1;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state       <= StIdle;
         r_valid       <= '0;
         r_ptr         <= '0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
         r_fail_code   <= 2'd0;
         r_match_count <= '0;
         r_cycle_count <= '0;
         r_err_addr    <= '0;
         r_err_data    <= '0;
         for (int i = 0; i < int'(NUM_EXP); i++) begin
            r_exp_addr[i] <= '0;
            r_exp_data[i] <= '0;
         end
      end else begin
         if (w_load) begin
            r_exp_addr[bus.exp_idx] <= bus.exp_addr;
            r_exp_data[bus.exp_idx] <= bus.exp_data;
            r_valid[bus.exp_idx]    <= 1'b1;
         end

         case (r_state)
            StIdle, StPass, StFail: begin
               if (bus.start) begin
                  r_ptr         <= '0;
                  r_match_count <= '0;
                  r_cycle_count <= '0;
                  r_err_addr    <= '0;
                  r_err_data    <= '0;
                  r_pass        <= 1'b0;
                  // Completeness is judged on the table as it stood before this edge.
                  if (MODE != 0 && !(&r_valid)) begin
                     r_state     <= StFail;
                     r_done      <= 1'b1;
                     r_fail_code <= 2'd3;
                  end else begin
                     r_state     <= StRun;
                     r_done      <= 1'b0;
                     r_fail_code <= 2'd0;
                  end
               end
            end

            StRun: begin
               r_cycle_count <= w_cycle_inc;
               if (bus.memwrite && MODE == 0) begin
                  r_state <= StPass;
                  r_done  <= 1'b1;
                  r_pass  <= 1'b1;
               end else if (bus.memwrite && w_hit) begin
                  r_ptr         <= r_ptr + 1'b1;
                  r_match_count <= r_match_count + 1'b1;
                  // Final match takes priority over a timeout on the same edge.
                  if (r_ptr == PTR_LAST) begin
                     r_state <= StPass;
                     r_done  <= 1'b1;
                     r_pass  <= 1'b1;
                  end else if (w_last_cycle) begin
                     r_state     <= StFail;
                     r_done      <= 1'b1;
                     r_fail_code <= 2'd2;
                  end
               end else if (bus.memwrite) begin
                  r_state     <= StFail;
                  r_done      <= 1'b1;
                  r_fail_code <= 2'd1;
                  r_err_addr  <= bus.dataadr;
                  r_err_data  <= bus.writedata;
               end else if (w_last_cycle) begin
                  r_state     <= StFail;
                  r_done      <= 1'b1;
                  r_fail_code <= 2'd2;
               end
            end

            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.done        = r_done;
   assign bus.pass        = r_pass;
   assign bus.fail_code   = r_fail_code;
   assign bus.match_count = r_match_count;
   assign bus.cycle_count = r_cycle_count;
   assign bus.err_addr    = r_err_addr;
   assign bus.err_data    = r_err_data;
endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: a MODE 0 and a MODE 1 instance (NUM_EXP=2,
// TIMEOUT_CYC=10) side by side. Expected results go into a queue as stimulus is driven and are
// popped and compared against the DUT outputs one cycle later.
module tb_mem_write_checker;
   typedef struct {
      logic        done;
      logic        pass;
      logic [1:0]  code;
      logic [1:0]  mc;
      logic [3:0]  cc;
      logic [31:0] ea;
      logic [31:0] ed;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_err = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   mem_write_checker_if #(.DATA_W(32), .ADDR_W(32), .NUM_EXP(2), .TIMEOUT_CYC(10)) if0 ();
   mem_write_checker_if #(.DATA_W(32), .ADDR_W(32), .NUM_EXP(2), .TIMEOUT_CYC(10)) if1 ();

   mem_write_checker #(.DATA_W(32), .ADDR_W(32), .NUM_EXP(2), .TIMEOUT_CYC(10), .MODE(0)) u_dut0 (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .bus       (if0)
   );

   mem_write_checker #(.DATA_W(32), .ADDR_W(32), .NUM_EXP(2), .TIMEOUT_CYC(10), .MODE(1)) u_dut1 (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .bus       (if1)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input logic d, input logic p, input logic [1:0] c,
                             input logic [1:0] mc, input logic [3:0] cc,
                             input logic [31:0] ea, input logic [31:0] ed);
      exp_t e;
      e.done = d; e.pass = p; e.code = c; e.mc = mc; e.cc = cc; e.ea = ea; e.ed = ed;
      sb_q.push_back(e);
   endtask

   task automatic check0(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_err++;
         $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
      end else begin
         e = sb_q.pop_front();
         cmp({tag, ".done"}, 32'(if0.done), 32'(e.done));
         cmp({tag, ".pass"}, 32'(if0.pass), 32'(e.pass));
         cmp({tag, ".fail_code"}, 32'(if0.fail_code), 32'(e.code));
         cmp({tag, ".match_count"}, 32'(if0.match_count), 32'(e.mc));
         cmp({tag, ".cycle_count"}, 32'(if0.cycle_count), 32'(e.cc));
         cmp({tag, ".err_addr"}, if0.err_addr, e.ea);
         cmp({tag, ".err_data"}, if0.err_data, e.ed);
      end
   endtask

   task automatic check1(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_err++;
         $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
      end else begin
         e = sb_q.pop_front();
         cmp({tag, ".done"}, 32'(if1.done), 32'(e.done));
         cmp({tag, ".pass"}, 32'(if1.pass), 32'(e.pass));
         cmp({tag, ".fail_code"}, 32'(if1.fail_code), 32'(e.code));
         cmp({tag, ".match_count"}, 32'(if1.match_count), 32'(e.mc));
         cmp({tag, ".cycle_count"}, 32'(if1.cycle_count), 32'(e.cc));
         cmp({tag, ".err_addr"}, if1.err_addr, e.ea);
         cmp({tag, ".err_data"}, if1.err_data, e.ed);
      end
   endtask

   task automatic load1(input logic idx, input logic [31:0] a, input logic [31:0] d);
      if1.exp_we = 1'b1; if1.exp_idx = idx; if1.exp_addr = a; if1.exp_data = d;
      tick(1);
      if1.exp_we = 1'b0;
   endtask

   task automatic start1();
      if1.start = 1'b1;
      tick(1);
      if1.start = 1'b0;
   endtask

   task automatic write1(input logic [31:0] a, input logic [31:0] d);
      if1.memwrite = 1'b1; if1.dataadr = a; if1.writedata = d;
      tick(1);
      if1.memwrite = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=time limit reached expected=bench finished");
      $fatal(1, "bench timed out");
   end

   initial begin
      if0.memwrite = 0; if0.dataadr = '0; if0.writedata = '0; if0.exp_we = 0;
      if0.exp_idx = '0; if0.exp_addr = '0; if0.exp_data = '0; if0.start = 0;
      if1.memwrite = 0; if1.dataadr = '0; if1.writedata = '0; if1.exp_we = 0;
      if1.exp_idx = '0; if1.exp_addr = '0; if1.exp_data = '0; if1.start = 0;

      // Reset state.
      tick(2);
      reset_n = 1'b1;
      expect_out(0, 0, 0, 0, 0, 0, 0); check0("reset_m0");
      expect_out(0, 0, 0, 0, 0, 0, 0); check1("reset_m1");

      // MODE 0: first write on the 3rd RUN edge passes.
      if0.start = 1'b1; tick(1); if0.start = 1'b0;
      tick(2);
      expect_out(0, 0, 0, 0, 2, 0, 0); check0("m0_running");
      if0.memwrite = 1'b1; if0.dataadr = 32'd100; if0.writedata = 32'd1;
      expect_out(1, 1, 0, 0, 3, 0, 0);
      tick(1); if0.memwrite = 1'b0;
      check0("m0_pass");
      tick(2);
      expect_out(1, 1, 0, 0, 3, 0, 0); check0("m0_sticky");

      // MODE 1: two identical matching writes.
      load1(1'b0, 32'd84, 32'd7);
      load1(1'b1, 32'd84, 32'd7);
      start1();
      expect_out(0, 0, 0, 1, 1, 0, 0); write1(32'd84, 32'd7); check1("m1_first_match");
      expect_out(1, 1, 0, 2, 2, 0, 0); write1(32'd84, 32'd7); check1("m1_pass");

      // MODE 1: second write mismatches on data.
      load1(1'b1, 32'd88, 32'd9);
      start1();
      write1(32'd84, 32'd7);
      expect_out(1, 0, 1, 1, 2, 32'd88, 32'd5); write1(32'd88, 32'd5); check1("m1_mismatch");

      // MODE 1: timeout with no writes.
      start1();
      expect_out(0, 0, 0, 0, 9, 0, 0); tick(9); check1("m1_pre_timeout");
      expect_out(1, 0, 2, 0, 10, 0, 0); tick(1); check1("m1_timeout");

      // MODE 1: final match lands on the timeout edge; a table write during RUN is ignored.
      start1();
      if1.exp_we = 1'b1; if1.exp_idx = 1'b1; if1.exp_addr = '0; if1.exp_data = '0;
      tick(1);
      if1.exp_we = 1'b0;
      tick(7);
      write1(32'd84, 32'd7);
      expect_out(1, 1, 0, 2, 10, 0, 0); write1(32'd88, 32'd9); check1("m1_match_on_timeout");

      // Reset mid-RUN, then incomplete-table start.
      start1();
      expect_out(0, 0, 0, 1, 1, 0, 0); write1(32'd84, 32'd7); check1("m1_before_reset");
      reset_n = 1'b0; tick(1); reset_n = 1'b1;
      expect_out(0, 0, 0, 0, 0, 0, 0); check1("m1_after_reset");
      expect_out(0, 0, 0, 0, 0, 0, 0); check0("m0_after_reset");
      expect_out(1, 0, 3, 0, 0, 0, 0); start1(); check1("m1_empty_table");
      load1(1'b0, 32'd84, 32'd7);
      expect_out(1, 0, 3, 0, 0, 0, 0); start1(); check1("m1_partial_table");

      // Full table again; start in RUN is ignored and idle cycles do not advance.
      load1(1'b1, 32'd88, 32'd9);
      start1();
      tick(1);
      if1.start = 1'b1;
      expect_out(0, 0, 0, 0, 2, 0, 0);
      tick(1);
      if1.start = 1'b0;
      check1("m1_start_in_run");
      write1(32'd84, 32'd7);
      expect_out(1, 1, 0, 2, 4, 0, 0); write1(32'd88, 32'd9); check1("m1_rerun_pass");

      if (sb_q.size() != 0) begin
         n_checks++;
         n_err++;
         $error("FAIL scoreboard_drain: observed=%0d left expected=0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
